// File: rtl/fpu_align_unpack_if.sv
// Operand/result handshake bundle for the FP add/sub alignment front end.
// master: operand producer and result consumer. slave: the alignment pipeline.
interface fpu_align_unpack_if #(
    parameter int MANT_W = 27,
    parameter int EXP_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       op_a;
    logic [31:0]       op_b;
    logic              op_sub;
    logic              out_valid;
    logic              out_ready;
    logic              is_add_path;
    logic              carry_out;
    logic [MANT_W-1:0] mant_out;
    logic [EXP_W-1:0]  exp_out;
    logic              sign_out;
    logic              is_nan;
    logic              is_inf;

    modport master (
        output in_valid, op_a, op_b, op_sub, out_ready,
        input  in_ready, out_valid, is_add_path, carry_out,
               mant_out, exp_out, sign_out, is_nan, is_inf
    );

    modport slave (
        input  in_valid, op_a, op_b, op_sub, out_ready,
        output in_ready, out_valid, is_add_path, carry_out,
               mant_out, exp_out, sign_out, is_nan, is_inf
    );
endinterface

// File: rtl/fpu_align_unpack.sv
// FP add/sub front end: unpack and classify two single-precision operands,
// swap by magnitude, align the smaller mantissa with guard/round/sticky, then
// perform the effective add or subtract. Two registered stages, valid/ready
// on both sides, no skid buffer.
module fpu_align_unpack #(
    parameter int MANT_W = 27,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    fpu_align_unpack_if.slave bus
);
    localparam int                FRAC_W  = MANT_W - 4;
    localparam logic [EXP_W-1:0]  EXP_MAX = '1;
    localparam logic [EXP_W-1:0]  D_LIMIT = EXP_W'(MANT_W);

    // ---------------- handshake ----------------
    logic w_s2_free;
    logic w_in_ready;
    logic w_accept;
    logic w_s2_load;
    logic r1_valid;
    logic r2_valid;

    assign w_s2_free  = ~r2_valid | bus.out_ready;
    assign w_in_ready = ~r1_valid | w_s2_free;
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_s2_load  = r1_valid & w_s2_free;

    // ---------------- stage 1: unpack / classify / swap ----------------
    logic              w_sa, w_sb;
    logic [EXP_W-1:0]  w_ea, w_eb;
    logic [FRAC_W-1:0] w_fa, w_fb;
    logic              w_nan_a, w_nan_b, w_inf_a, w_inf_b;
    logic              w_zero_a, w_zero_b;
    logic [MANT_W-1:0] w_ma, w_mb;
    logic              w_swap;
    logic [EXP_W-1:0]  w_el, w_es, w_d;
    logic              w_sl, w_ss;
    logic [MANT_W-1:0] w_ml, w_ms;
    logic [MANT_W-1:0] w_lost_mask;
    logic [MANT_W-1:0] w_ms_al;
    logic              w_eff_sub;
    logic              w_nan, w_inf;

    assign w_sa = bus.op_a[31];
    assign w_ea = bus.op_a[FRAC_W +: EXP_W];
    assign w_fa = bus.op_a[FRAC_W-1:0];
    // B's sign is folded with the opcode so everything downstream is an add
    assign w_sb = bus.op_b[31] ^ bus.op_sub;
    assign w_eb = bus.op_b[FRAC_W +: EXP_W];
    assign w_fb = bus.op_b[FRAC_W-1:0];

    assign w_nan_a  = (w_ea == EXP_MAX) &  (|w_fa);
    assign w_inf_a  = (w_ea == EXP_MAX) & ~(|w_fa);
    assign w_nan_b  = (w_eb == EXP_MAX) &  (|w_fb);
    assign w_inf_b  = (w_eb == EXP_MAX) & ~(|w_fb);
    assign w_zero_a = (w_ea == '0);
    assign w_zero_b = (w_eb == '0);

    // denormals flush to zero: hidden bit and fraction both dropped
    assign w_ma = w_zero_a ? '0 : {1'b1, w_fa, 3'b000};
    assign w_mb = w_zero_b ? '0 : {1'b1, w_fb, 3'b000};

    // ties keep A as the larger operand
    assign w_swap = {w_eb, w_fb} > {w_ea, w_fa};
    assign w_el   = w_swap ? w_eb : w_ea;
    assign w_es   = w_swap ? w_ea : w_eb;
    assign w_sl   = w_swap ? w_sb : w_sa;
    assign w_ss   = w_swap ? w_sa : w_sb;
    assign w_ml   = w_swap ? w_mb : w_ma;
    assign w_ms   = w_swap ? w_ma : w_mb;
    assign w_d    = w_el - w_es;

    assign w_eff_sub = w_sl ^ w_ss;
    assign w_nan     = w_nan_a | w_nan_b | (w_inf_a & w_inf_b & w_eff_sub);
    assign w_inf     = ~w_nan & (w_inf_a | w_inf_b);

    // Right-shift the smaller mantissa, folding every shifted-out bit into bit 0
    always_comb begin
        w_lost_mask = ~({MANT_W{1'b1}} << w_d[4:0]);
        if (w_d >= D_LIMIT) begin
            w_ms_al = {{(MANT_W-1){1'b0}}, |w_ms};
        end else begin
            w_ms_al = (w_ms >> w_d[4:0]) | {{(MANT_W-1){1'b0}}, |(w_ms & w_lost_mask)};
        end
    end

    logic [MANT_W-1:0] r1_ml;
    logic [MANT_W-1:0] r1_ms;
    logic [EXP_W-1:0]  r1_el;
    logic              r1_sl;
    logic              r1_ss;
    logic              r1_eff_sub;
    logic              r1_nan;
    logic              r1_inf;
    logic              r1_zero;

    // Pipeline occupancy bits; a stage empties only when its contents move on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r2_valid <= 1'b0;
        end else begin
            r1_valid <= w_accept  | (r1_valid & ~w_s2_free);
            r2_valid <= w_s2_load | (r2_valid & ~bus.out_ready);
        end
    end

    // Capture the swapped/aligned operand bundle on each accepted transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_ml      <= '0;
            r1_ms      <= '0;
            r1_el      <= '0;
            r1_sl      <= 1'b0;
            r1_ss      <= 1'b0;
            r1_eff_sub <= 1'b0;
            r1_nan     <= 1'b0;
            r1_inf     <= 1'b0;
            r1_zero    <= 1'b0;
        end else if (w_accept) begin
            r1_ml      <= w_ml;
            r1_ms      <= w_ms_al;
            r1_el      <= w_el;
            r1_sl      <= w_sl;
            r1_ss      <= w_ss;
            r1_eff_sub <= w_eff_sub;
            r1_nan     <= w_nan;
            r1_inf     <= w_inf;
            r1_zero    <= w_zero_a & w_zero_b;
        end
    end

    // ---------------- stage 2: effective add / subtract ----------------
    logic [MANT_W:0]   w_sum;
    logic [MANT_W-1:0] w_diff;
    logic              w_add_path;
    logic              w_carry;
    logic [MANT_W-1:0] w_mant;
    logic [EXP_W-1:0]  w_exp;
    logic              w_sign;
    logic              w_is_nan;
    logic              w_is_inf;

    assign w_sum  = {1'b0, r1_ml} + {1'b0, r1_ms};
    // the magnitude swap guarantees mL >= mS, so this never wraps
    assign w_diff = r1_ml - r1_ms;

    // Result selection: datapath, then zero/cancellation signs, then specials override
    always_comb begin
        w_add_path = ~r1_eff_sub;
        w_carry    = r1_eff_sub ? 1'b0 : w_sum[MANT_W];
        w_mant     = r1_eff_sub ? w_diff : w_sum[MANT_W-1:0];
        w_exp      = r1_el;
        w_sign     = r1_sl;
        w_is_nan   = 1'b0;
        w_is_inf   = 1'b0;
        if (r1_zero) begin
            w_sign  = r1_sl & r1_ss;
            w_mant  = '0;
            w_exp   = '0;
            w_carry = 1'b0;
        end else if (r1_eff_sub && (w_diff == '0)) begin
            w_sign = 1'b0;
        end
        if (r1_nan) begin
            w_is_nan = 1'b1;
            w_mant   = '0;
            w_exp    = EXP_MAX;
            w_sign   = 1'b0;
            w_carry  = 1'b0;
        end else if (r1_inf) begin
            // an Inf always wins the magnitude compare, so L carries its sign
            w_is_inf = 1'b1;
            w_mant   = '0;
            w_exp    = EXP_MAX;
            w_carry  = 1'b0;
        end
    end

    logic              r_add_path;
    logic              r_carry;
    logic [MANT_W-1:0] r_mant;
    logic [EXP_W-1:0]  r_exp;
    logic              r_sign;
    logic              r_is_nan;
    logic              r_is_inf;

    // Output registers load only when stage 2 is free, so they hold under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_add_path <= 1'b0;
            r_carry    <= 1'b0;
            r_mant     <= '0;
            r_exp      <= '0;
            r_sign     <= 1'b0;
            r_is_nan   <= 1'b0;
            r_is_inf   <= 1'b0;
        end else if (w_s2_load) begin
            r_add_path <= w_add_path;
            r_carry    <= w_carry;
            r_mant     <= w_mant;
            r_exp      <= w_exp;
            r_sign     <= w_sign;
            r_is_nan   <= w_is_nan;
            r_is_inf   <= w_is_inf;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r2_valid;
    assign bus.is_add_path = r_add_path;
    assign bus.carry_out   = r_carry;
    assign bus.mant_out    = r_mant;
    assign bus.exp_out     = r_exp;
    assign bus.sign_out    = r_sign;
    assign bus.is_nan      = r_is_nan;
    assign bus.is_inf      = r_is_inf;
endmodule
